// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one DW-bit register between NREQ writers, with optional lock.
// Define HOLD_TIMEOUT_EN to force-release an ownership after MAX_HOLD consecutive grant cycles.
module shared_reg_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*DW-1:0]      wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [DW-1:0]           q,
  output logic                    q_upd,
  output logic                    timeout
);

  localparam int unsigned OW = $clog2(NREQ);

  if (NREQ < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("shared_reg_arbiter: NREQ and MAX_HOLD must both be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StOwn} state_e;

  state_e          state_q;
  logic [OW-1:0]   ptr_q;
  logic [OW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            found;
  logic [DW-1:0]   owner_data;
  logic            owner_keep;

`ifdef HOLD_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q;
`endif

  // First requester at or after ptr+1, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned   idx;
      logic [OW-1:0] cand;
      idx  = (32'(ptr_q) + i) % NREQ;
      cand = OW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_oh[win] = 1'b1;
  end

  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (OW'(i) == owner) begin
        owner_data = wdata[i*DW +: DW];
      end
    end
  end

  assign owner_keep = req[owner] & lock[owner];
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= StIdle;
      gnt     <= '0;
      owner   <= '0;
      ptr_q   <= OW'(NREQ - 1);
      q       <= '0;
      q_upd   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      q_upd <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (found) begin
            gnt     <= win_oh;
            owner   <= win;
            ptr_q   <= win;
            state_q <= StGrant;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_q <= HW'(1);
`endif
          end
        end
        StGrant, StOwn: begin
          // The owner's write lands even on the edge that ends its ownership.
          if (req[owner]) begin
            q     <= owner_data;
            q_upd <= 1'b1;
          end
          if (owner_keep) begin
`ifdef HOLD_TIMEOUT_EN
            if (hold_cnt_q == HW'(MAX_HOLD)) begin
              state_q <= StIdle;
              gnt     <= '0;
              timeout <= 1'b1;
            end else begin
              state_q    <= StOwn;
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
`else
            state_q <= StOwn;
`endif
          end else begin
            state_q <= StIdle;
            gnt     <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
        end
      endcase
    end
  end

`ifndef HOLD_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
